// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: bundle layout, instruction
// encodings and ALU control codes.
`timescale 1ns/1ps
package ctrl_pkg;

    localparam int CTRL_W = 24;

    // Bundle bit positions, MSB to LSB
    localparam int B_VALID      = 23;
    localparam int B_ALU_LO     = 18;   // alucontrol occupies [22:18]
    localparam int B_MEMTOREG   = 17;
    localparam int B_MEMWRITE   = 16;
    localparam int B_MEMREAD    = 15;
    localparam int B_BRANCH     = 14;
    localparam int B_ALUSRC     = 13;
    localparam int B_REGDST_LO  = 11;   // regdst occupies [12:11]
    localparam int B_REGWRITE   = 10;
    localparam int B_JUMP       = 9;
    localparam int B_HILO_WRITE = 8;
    localparam int B_JBRAL      = 7;
    localparam int B_JR         = 6;
    localparam int B_CP0_WRITE  = 5;
    localparam int B_IS_INVALID = 4;
    localparam int B_HILOTOREG  = 3;
    localparam int B_CP0TOREG   = 2;
    localparam int B_MFHILO_LO  = 0;    // mfhi_lo occupies [1:0]

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MFHILO_LO = 2'b01;
    localparam logic [1:0] MFHILO_HI = 2'b10;

    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_AND   = 5'd1;
    localparam logic [4:0] ALU_OR    = 5'd2;
    localparam logic [4:0] ALU_XOR   = 5'd3;
    localparam logic [4:0] ALU_NOR   = 5'd4;
    localparam logic [4:0] ALU_ADD   = 5'd5;
    localparam logic [4:0] ALU_ADDU  = 5'd6;
    localparam logic [4:0] ALU_SUB   = 5'd7;
    localparam logic [4:0] ALU_SUBU  = 5'd8;
    localparam logic [4:0] ALU_SLT   = 5'd9;
    localparam logic [4:0] ALU_SLTU  = 5'd10;
    localparam logic [4:0] ALU_SLL   = 5'd11;
    localparam logic [4:0] ALU_SRL   = 5'd12;
    localparam logic [4:0] ALU_SRA   = 5'd13;
    localparam logic [4:0] ALU_SLLV  = 5'd14;
    localparam logic [4:0] ALU_SRLV  = 5'd15;
    localparam logic [4:0] ALU_SRAV  = 5'd16;
    localparam logic [4:0] ALU_LUI   = 5'd17;
    localparam logic [4:0] ALU_MULT  = 5'd18;
    localparam logic [4:0] ALU_MULTU = 5'd19;
    localparam logic [4:0] ALU_DIV   = 5'd20;
    localparam logic [4:0] ALU_DIVU  = 5'd21;
    localparam logic [4:0] ALU_MTHI  = 5'd22;
    localparam logic [4:0] ALU_MTLO  = 5'd23;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    localparam logic [4:0] RS_MFC0 = 5'h00;
    localparam logic [4:0] RS_MTC0 = 5'h04;

    function automatic logic isMulDiv(input logic [4:0] alu);
        return (alu == ALU_MULT) || (alu == ALU_MULTU) ||
               (alu == ALU_DIV)  || (alu == ALU_DIVU);
    endfunction

    function automatic logic isDiv(input logic [4:0] alu);
        return (alu == ALU_DIV) || (alu == ALU_DIVU);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder producing the packed control bundle.
// Reserved fields are checked so malformed encodings decode as invalid.
`timescale 1ns/1ps
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic              valid,
    output logic [CTRL_W-1:0] ctrl
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign sa    = instr[10:6];
    assign funct = instr[5:0];

    logic [CTRL_W-1:0] c;
    logic              inv;

    always_comb begin
        c   = CTRL_BUBBLE;
        inv = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLLV, F_SRLV, F_SRAV,
                    F_SLL, F_SRL, F_SRA: begin
                        case (funct)
                            F_ADD:   c[B_ALU_LO+:5] = ALU_ADD;
                            F_ADDU:  c[B_ALU_LO+:5] = ALU_ADDU;
                            F_SUB:   c[B_ALU_LO+:5] = ALU_SUB;
                            F_SUBU:  c[B_ALU_LO+:5] = ALU_SUBU;
                            F_AND:   c[B_ALU_LO+:5] = ALU_AND;
                            F_OR:    c[B_ALU_LO+:5] = ALU_OR;
                            F_XOR:   c[B_ALU_LO+:5] = ALU_XOR;
                            F_NOR:   c[B_ALU_LO+:5] = ALU_NOR;
                            F_SLT:   c[B_ALU_LO+:5] = ALU_SLT;
                            F_SLTU:  c[B_ALU_LO+:5] = ALU_SLTU;
                            F_SLLV:  c[B_ALU_LO+:5] = ALU_SLLV;
                            F_SRLV:  c[B_ALU_LO+:5] = ALU_SRLV;
                            F_SRAV:  c[B_ALU_LO+:5] = ALU_SRAV;
                            F_SLL:   c[B_ALU_LO+:5] = ALU_SLL;
                            F_SRL:   c[B_ALU_LO+:5] = ALU_SRL;
                            default: c[B_ALU_LO+:5] = ALU_SRA;
                        endcase
                        c[B_REGDST_LO+:2] = REGDST_RD;
                        c[B_REGWRITE]     = 1'b1;
                        // Immediate shifts must have rs = 0; all others shamt = 0
                        if (funct == F_SLL || funct == F_SRL || funct == F_SRA)
                            inv = (rs != 5'd0);
                        else
                            inv = (sa != 5'd0);
                    end
                    F_JR: begin
                        c[B_JR]   = 1'b1;
                        c[B_JUMP] = 1'b1;
                        inv       = ({rt, rd} != 10'd0);
                    end
                    F_JALR: begin
                        c[B_JR]           = 1'b1;
                        c[B_JUMP]         = 1'b1;
                        c[B_JBRAL]        = 1'b1;
                        c[B_REGWRITE]     = 1'b1;
                        c[B_REGDST_LO+:2] = REGDST_RD;
                        inv               = (rt != 5'd0);
                    end
                    F_MFHI, F_MFLO: begin
                        c[B_HILOTOREG]     = 1'b1;
                        c[B_MFHILO_LO+:2]  = (funct == F_MFHI) ? MFHILO_HI : MFHILO_LO;
                        c[B_REGWRITE]      = 1'b1;
                        c[B_REGDST_LO+:2]  = REGDST_RD;
                        inv                = ({rs, rt, sa} != 15'd0);
                    end
                    F_MTHI, F_MTLO: begin
                        c[B_HILO_WRITE] = 1'b1;
                        c[B_ALU_LO+:5]  = (funct == F_MTHI) ? ALU_MTHI : ALU_MTLO;
                        inv             = ({rt, rd, sa} != 15'd0);
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        c[B_HILO_WRITE] = 1'b1;
                        case (funct)
                            F_MULT:  c[B_ALU_LO+:5] = ALU_MULT;
                            F_MULTU: c[B_ALU_LO+:5] = ALU_MULTU;
                            F_DIV:   c[B_ALU_LO+:5] = ALU_DIV;
                            default: c[B_ALU_LO+:5] = ALU_DIVU;
                        endcase
                        inv = ({rd, sa} != 10'd0);
                    end
                    default: inv = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ: c[B_BRANCH] = 1'b1;
                    RT_BLTZAL, RT_BGEZAL: begin
                        c[B_BRANCH]       = 1'b1;
                        c[B_JBRAL]        = 1'b1;
                        c[B_REGWRITE]     = 1'b1;
                        c[B_REGDST_LO+:2] = REGDST_RA;
                    end
                    default: inv = 1'b1;
                endcase
            end
            OP_J: c[B_JUMP] = 1'b1;
            OP_JAL: begin
                c[B_JUMP]         = 1'b1;
                c[B_JBRAL]        = 1'b1;
                c[B_REGWRITE]     = 1'b1;
                c[B_REGDST_LO+:2] = REGDST_RA;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                c[B_BRANCH]    = 1'b1;
                c[B_ALU_LO+:5] = ALU_SUBU;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                case (op)
                    OP_ADDI:  c[B_ALU_LO+:5] = ALU_ADD;
                    OP_ADDIU: c[B_ALU_LO+:5] = ALU_ADDU;
                    OP_SLTI:  c[B_ALU_LO+:5] = ALU_SLT;
                    OP_SLTIU: c[B_ALU_LO+:5] = ALU_SLTU;
                    OP_ANDI:  c[B_ALU_LO+:5] = ALU_AND;
                    OP_ORI:   c[B_ALU_LO+:5] = ALU_OR;
                    OP_XORI:  c[B_ALU_LO+:5] = ALU_XOR;
                    default:  c[B_ALU_LO+:5] = ALU_LUI;
                endcase
                c[B_ALUSRC]   = 1'b1;
                c[B_REGWRITE] = 1'b1;
                inv           = (op == OP_LUI) && (rs != 5'd0);
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                c[B_ALU_LO+:5] = ALU_ADDU;
                c[B_ALUSRC]    = 1'b1;
                c[B_MEMREAD]   = 1'b1;
                c[B_MEMTOREG]  = 1'b1;
                c[B_REGWRITE]  = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                c[B_ALU_LO+:5] = ALU_ADDU;
                c[B_ALUSRC]    = 1'b1;
                c[B_MEMWRITE]  = 1'b1;
            end
            OP_COP0: begin
                case (rs)
                    RS_MFC0: begin
                        c[B_CP0TOREG]     = 1'b1;
                        c[B_REGWRITE]     = 1'b1;
                        c[B_REGDST_LO+:2] = REGDST_RT;
                        inv               = (instr[10:3] != 8'd0);
                    end
                    RS_MTC0: begin
                        c[B_CP0_WRITE] = 1'b1;
                        inv            = (instr[10:3] != 8'd0);
                    end
                    default: inv = 1'b1;
                endcase
            end
            default: inv = 1'b1;
        endcase

        // Invalid encodings still travel down the pipe so M can trap them
        if (inv) begin
            c               = CTRL_BUBBLE;
            c[B_IS_INVALID] = 1'b1;
        end
        if (valid) c[B_VALID] = 1'b1;
        else       c = CTRL_BUBBLE;
    end

    assign ctrl = c;

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decoded control bundles and PCs through E/M/W with stall/flush
// handling, and sequences multi-cycle mult/div occupancy of E.
`timescale 1ns/1ps
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int DIV_CYCLES  = 34,
    parameter int MULT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instrD,
    input  logic              validD,
    input  logic [PC_W-1:0]   pcD,
    input  logic              stallE,
    input  logic              stallM,
    input  logic              stallW,
    input  logic              flushE,
    input  logic              flushM,
    input  logic              flushW,
    input  logic              flush_exc,
    output logic [CTRL_W-1:0] ctrlD,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [CTRL_W-1:0] ctrlM,
    output logic [CTRL_W-1:0] ctrlW,
    output logic [PC_W-1:0]   pcE,
    output logic [PC_W-1:0]   pcM,
    output logic [PC_W-1:0]   pcW,
    output logic              md_startE,
    output logic              md_busyE,
    output logic              stall_req
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    ctrl_decode uDecode (
        .instr (instrD),
        .valid (validD),
        .ctrl  (ctrlD)
    );

    logic [CNT_W-1:0] mdCnt;
    logic             flushEAny;
    logic             flushMAny;
    logic             flushWAny;
    logic             holdE;
    logic             loadE;
    logic             mdIncoming;
    logic             mdIncomingDiv;
    logic             mdLong;
    logic [CNT_W-1:0] mdInit;

    assign flushEAny = flush_exc | flushE;
    assign flushMAny = flush_exc | flushM;
    assign flushWAny = flush_exc | flushW;
    assign holdE     = stallE | md_busyE;
    assign loadE     = !flushEAny && !holdE;

    assign mdIncoming    = ctrlD[B_VALID] && isMulDiv(ctrlD[B_ALU_LO+:5]);
    assign mdIncomingDiv = isDiv(ctrlD[B_ALU_LO+:5]);
    assign mdInit        = mdIncomingDiv ? DIV_INIT : MULT_INIT;
    assign mdLong        = mdIncomingDiv ? (DIV_CYCLES > 1) : (MULT_CYCLES > 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrlE <= CTRL_BUBBLE;
            pcE   <= '0;
        end else if (flushEAny) begin
            ctrlE <= CTRL_BUBBLE;
            pcE   <= '0;
        end else if (!holdE) begin
            ctrlE <= ctrlD;
            pcE   <= pcD;
        end
    end

    // While E is pinned by a multi-cycle op, M must not see copies of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrlM <= CTRL_BUBBLE;
            pcM   <= '0;
        end else if (flushMAny) begin
            ctrlM <= CTRL_BUBBLE;
            pcM   <= '0;
        end else if (!stallM) begin
            if (md_busyE) begin
                ctrlM <= CTRL_BUBBLE;
                pcM   <= '0;
            end else begin
                ctrlM <= ctrlE;
                pcM   <= pcE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrlW <= CTRL_BUBBLE;
            pcW   <= '0;
        end else if (flushWAny) begin
            ctrlW <= CTRL_BUBBLE;
            pcW   <= '0;
        end else if (!stallW) begin
            ctrlW <= ctrlM;
            pcW   <= pcM;
        end
    end

    // Counter runs regardless of stallE; busy drops on the 1->0 step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdCnt     <= '0;
            md_busyE  <= 1'b0;
            md_startE <= 1'b0;
        end else begin
            md_startE <= loadE && mdIncoming;
            if (flushEAny) begin
                mdCnt    <= '0;
                md_busyE <= 1'b0;
            end else if (md_busyE) begin
                mdCnt <= mdCnt - CNT_ONE;
                if (mdCnt == CNT_ONE) md_busyE <= 1'b0;
            end else if (loadE && mdIncoming && mdLong) begin
                mdCnt    <= mdInit;
                md_busyE <= 1'b1;
            end
        end
    end

    assign stall_req = md_busyE;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed-vector bench for ctrl_pipeline with hand-computed control bundles.
`timescale 1ns/1ps
module tb_ctrl_pipeline;

    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_DIV  = 32'h0022001A;
    localparam logic [31:0] I_MULT = 32'h00220018;
    localparam logic [31:0] I_BAD  = 32'hFC000000;

    // Expected bundles, assembled by hand from the field layout
    localparam logic [23:0] C_ADDU = 24'h980C00;  // valid, alu=ADDU(6), regdst=01, regwrite
    localparam logic [23:0] C_LW   = 24'h9AA400;  // + memtoreg, memread, alusrc, regdst=00
    localparam logic [23:0] C_DIV  = 24'hD00100;  // valid, alu=DIV(20), hilo_write
    localparam logic [23:0] C_MULT = 24'hC80100;  // valid, alu=MULT(18), hilo_write
    localparam logic [23:0] C_BAD  = 24'h800010;  // valid, is_invalid

    logic        clk;
    logic        rst;
    logic [31:0] instrD;
    logic        validD;
    logic [31:0] pcD;
    logic        stallE, stallM, stallW;
    logic        flushE, flushM, flushW;
    logic        flush_exc;
    logic [23:0] ctrlD, ctrlE, ctrlM, ctrlW;
    logic [31:0] pcE, pcM, pcW;
    logic        md_startE, md_busyE, stall_req;

    int nVec  = 0;
    int nMiss = 0;
    int starts;

    ctrl_pipeline dut (
        .clk       (clk),
        .rst       (rst),
        .instrD    (instrD),
        .validD    (validD),
        .pcD       (pcD),
        .stallE    (stallE),
        .stallM    (stallM),
        .stallW    (stallW),
        .flushE    (flushE),
        .flushM    (flushM),
        .flushW    (flushW),
        .flush_exc (flush_exc),
        .ctrlD     (ctrlD),
        .ctrlE     (ctrlE),
        .ctrlM     (ctrlM),
        .ctrlW     (ctrlW),
        .pcE       (pcE),
        .pcM       (pcM),
        .pcW       (pcW),
        .md_startE (md_startE),
        .md_busyE  (md_busyE),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instrD = '0; validD = 1'b0; pcD = '0;
        stallE = 0; stallM = 0; stallW = 0;
        flushE = 0; flushM = 0; flushW = 0; flush_exc = 0;
        #2;
        checkVal("reset ctrlE", {8'd0, ctrlE}, 32'd0);
        checkVal("reset ctrlM", {8'd0, ctrlM}, 32'd0);
        checkVal("reset ctrlW", {8'd0, ctrlW}, 32'd0);
        checkVal("reset pcW", pcW, 32'd0);
        checkVal("reset md", {29'd0, md_startE, md_busyE, stall_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Straight-line flow: addu then lw
        instrD = I_ADDU; validD = 1'b1; pcD = 32'hBFC00000;
        #1;
        checkVal("addu ctrlD", {8'd0, ctrlD}, {8'd0, C_ADDU});
        step();
        checkVal("addu ctrlE", {8'd0, ctrlE}, {8'd0, C_ADDU});
        checkVal("addu pcE", pcE, 32'hBFC00000);
        instrD = I_LW; pcD = 32'hBFC00004;
        step();
        checkVal("addu ctrlM", {8'd0, ctrlM}, {8'd0, C_ADDU});
        checkVal("addu pcM", pcM, 32'hBFC00000);
        checkVal("lw ctrlE", {8'd0, ctrlE}, {8'd0, C_LW});
        validD = 1'b0; instrD = '0; pcD = '0;
        step();
        checkVal("addu ctrlW", {8'd0, ctrlW}, {8'd0, C_ADDU});
        checkVal("addu pcW", pcW, 32'hBFC00000);
        checkVal("lw ctrlM", {8'd0, ctrlM}, {8'd0, C_LW});
        checkVal("bubble ctrlE", {8'd0, ctrlE}, 32'd0);
        step();
        checkVal("lw ctrlW", {8'd0, ctrlW}, {8'd0, C_LW});
        checkVal("lw pcW", pcW, 32'hBFC00004);

        // Stall holds E; flush wins over stall
        instrD = I_ADDU; validD = 1'b1; pcD = 32'h100;
        step();
        stallE = 1'b1; instrD = I_LW; pcD = 32'h104;
        step();
        step();
        checkVal("stallE ctrlE", {8'd0, ctrlE}, {8'd0, C_ADDU});
        checkVal("stallE pcE", pcE, 32'h100);
        flushE = 1'b1;
        step();
        checkVal("flush>stall ctrlE", {8'd0, ctrlE}, 32'd0);
        checkVal("flush>stall pcE", pcE, 32'd0);
        stallE = 1'b0; flushE = 1'b0; validD = 1'b0; pcD = '0;

        // Asynchronous reset mid-cycle
        instrD = I_ADDU; validD = 1'b1; pcD = 32'h200;
        step();
        step();
        validD = 1'b0; pcD = '0;
        #3;
        rst = 1'b1;
        #1;
        checkVal("async rst ctrlE", {8'd0, ctrlE}, 32'd0);
        checkVal("async rst ctrlM", {8'd0, ctrlM}, 32'd0);
        checkVal("async rst pcM", pcM, 32'd0);
        #1;
        rst = 1'b0;

        // Divide occupies E for 34 cycles
        instrD = I_DIV; validD = 1'b1; pcD = 32'h300;
        #1;
        checkVal("div ctrlD", {8'd0, ctrlD}, {8'd0, C_DIV});
        step();
        checkVal("div start", {29'd0, md_startE, md_busyE, stall_req}, 32'b111);
        checkVal("div ctrlE", {8'd0, ctrlE}, {8'd0, C_DIV});
        starts = md_startE ? 1 : 0;
        instrD = I_ADDU; pcD = 32'h304;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (md_startE) starts++;
            checkVal("div busy", {30'd0, md_busyE, stall_req}, 32'b11);
            checkVal("div ctrlM bubble", {8'd0, ctrlM}, 32'd0);
            checkVal("div ctrlE held", {8'd0, ctrlE}, {8'd0, C_DIV});
        end
        step();
        if (md_startE) starts++;
        checkVal("div busy clear", {30'd0, md_busyE, stall_req}, 32'd0);
        checkVal("div still in E", {8'd0, ctrlE}, {8'd0, C_DIV});
        checkVal("div M empty", {8'd0, ctrlM}, 32'd0);
        step();
        if (md_startE) starts++;
        checkVal("div ctrlM", {8'd0, ctrlM}, {8'd0, C_DIV});
        checkVal("div pcM", pcM, 32'h300);
        checkVal("post-div ctrlE", {8'd0, ctrlE}, {8'd0, C_ADDU});
        checkVal("post-div pcE", pcE, 32'h304);
        checkVal("div start count", starts, 32'd1);
        validD = 1'b0; pcD = '0;
        step();
        step();

        // Exception flush in busy cycle 10
        instrD = I_DIV; validD = 1'b1; pcD = 32'h400;
        step();
        validD = 1'b0; pcD = '0;
        repeat (9) step();
        checkVal("exc pre busy", {31'd0, md_busyE}, 32'd1);
        flush_exc = 1'b1;
        step();
        checkVal("exc ctrlE", {8'd0, ctrlE}, 32'd0);
        checkVal("exc ctrlM", {8'd0, ctrlM}, 32'd0);
        checkVal("exc ctrlW", {8'd0, ctrlW}, 32'd0);
        checkVal("exc md", {29'd0, md_startE, md_busyE, stall_req}, 32'd0);
        flush_exc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("exc no restart", {30'd0, md_startE, md_busyE}, 32'd0);
        end

        // Invalid opcode propagates unchanged to W
        instrD = I_BAD; validD = 1'b1; pcD = 32'h500;
        #1;
        checkVal("bad ctrlD", {8'd0, ctrlD}, {8'd0, C_BAD});
        step();
        validD = 1'b0; pcD = '0;
        step();
        step();
        checkVal("bad ctrlW", {8'd0, ctrlW}, {8'd0, C_BAD});
        checkVal("bad pcW", pcW, 32'h500);

        // Single-cycle mult: start pulse without busy
        instrD = I_MULT; validD = 1'b1; pcD = 32'h600;
        step();
        checkVal("mult ctrlE", {8'd0, ctrlE}, {8'd0, C_MULT});
        checkVal("mult start", {30'd0, md_startE, md_busyE}, 32'b10);
        validD = 1'b0; pcD = '0;
        step();
        checkVal("mult start once", {30'd0, md_startE, md_busyE}, 32'd0);
        checkVal("mult ctrlM", {8'd0, ctrlM}, {8'd0, C_MULT});

        // Div arriving with flushE is never started
        instrD = I_DIV; validD = 1'b1; pcD = 32'h700; flushE = 1'b1;
        step();
        checkVal("flushE div ctrlE", {8'd0, ctrlE}, 32'd0);
        checkVal("flushE div md", {30'd0, md_startE, md_busyE}, 32'd0);
        flushE = 1'b0; validD = 1'b0; pcD = '0;

        // flushW beats stallW
        instrD = I_ADDU; validD = 1'b1; pcD = 32'h800;
        step();
        validD = 1'b0; pcD = '0;
        step();
        stallW = 1'b1; flushW = 1'b1;
        step();
        checkVal("flushW>stallW ctrlW", {8'd0, ctrlW}, 32'd0);
        stallW = 1'b0; flushW = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Decodes the D-stage instruction into a packed control bundle.
- Carries that bundle, with its PC, through the E, M and W pipeline registers.
- Per-stage stall and flush, plus an exception flush that clears all three stages.
- Tracks multi-cycle mult/div in E: holds E, bubbles M, and raises a stall request to the hazard unit until the operation completes.

Parameters:
- PC_W, 32, width of the PC carried alongside each bundle.
- DIV_CYCLES, 34, total cycles a div/divu occupies E (≥1).
- MULT_CYCLES, 1, total cycles a mult/multu occupies E (≥1; 1 = no extra stall).
- CNT_W, $clog2(max(DIV_CYCLES,MULT_CYCLES)+1), width of the multi-cycle counter (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instrD  in  32  D-stage instruction.
- validD  in  1  D holds a real instruction; 0 = bubble.
- pcD  in  PC_W  D-stage PC.
- stallE, stallM, stallW  in  1 each  hold that stage register.
- flushE, flushM, flushW  in  1 each  load a bubble into that stage.
- flush_exc  in  1  exception flush; clears E, M and W.
- ctrlD  out  CTRL_W  combinational decode of instrD; valid bit = validD.
- ctrlE, ctrlM, ctrlW  out  CTRL_W each  registered bundles.
- pcE, pcM, pcW  out  PC_W each  registered PCs.
- md_startE  out  1  one-cycle pulse: a mult/div entered E, start the functional unit.
- md_busyE  out  1  multi-cycle op in progress.
- stall_req  out  1  request to the hazard unit to stall F/D/E.

Behaviour:
- Bundle layout (MSB→LSB): valid, alucontrol[4:0], memtoreg, memwrite, memread, branch, alusrc, regdst[1:0], regwrite, jump, hilo_write, jbral, jr, cp0_write, is_invalid, hilotoreg, cp0toreg, mfhi_lo[1:0]. CTRL_W = 24.
- Bubble = all-zero bundle and PC = 0.
- Reset (async, rst=1): ctrlE/M/W = 0, pcE/M/W = 0, counter = 0, md_busyE = 0, md_startE = 0, stall_req = 0.
- Register update per stage X, in priority order:
  - flush_exc → bubble.
  - flushX → bubble. Flush beats a simultaneous stallX.
  - stallX, or (X=E and md_busyE) → hold.
  - Otherwise load from the previous stage.
- Special source for M: when md_busyE=1 and E is not advancing, M loads a bubble rather than a copy of E.
- Stage latency: D→E→M→W, one cycle per stage with no stalls.
- Multi-cycle start:
  - Trigger: a valid div/divu/mult/multu bundle is loaded into E and N = (DIV_CYCLES or MULT_CYCLES) > 1.
  - The same edge sets counter = N-1, md_busyE = 1, md_startE = 1 for exactly one cycle.
  - If N = 1: no busy, but md_startE still pulses.
- While md_busyE = 1:
  - The counter decrements each cycle, ignoring stallE.
  - md_busyE clears on the edge where the counter goes 1→0. E advances on the next non-stalled edge.
- stall_req = md_busyE. It is combinationally high from the cycle after start until the busy clear.
- flush_exc mid-operation: counter → 0, md_busyE → 0, no md_startE.
- flushE mid-operation: same as flush_exc for E only. The result is discarded.
- A mult/div entering E on the same edge as flush_exc or flushE is not started.
- Back-to-back mult/div: the second one starts only when it is actually loaded into E after the first has completed.
- Invalid opcode: is_invalid = 1 and all other control fields = 0. The bundle still propagates so that M can raise a reserved-instruction exception.

Decomposition:
- Package ctrl_pkg:
  - CTRL_W and bit-position constants for every bundle field.
  - Opcode/funct constants.
  - ALU control codes, including the div/divu/mult/multu codes used for detection.
  - CTRL_BUBBLE constant.
- Sub-module ctrl_decode: purely combinational instr→bundle table, instantiated once for ctrlD.
- Stage registers, counter and the priority logic stay in ctrl_pipeline.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately, before the next clk edge.
2. Pipeline flow: addu $3,$1,$2 (0x00221821), pcD=0xBFC00000, no stalls → ctrlE at +1, ctrlM at +2, ctrlW at +3, each with regwrite=1, regdst=01, pc=0xBFC00000. lw (0x8C220004) follows with memread=1 and memtoreg=1 one cycle behind.
3. Stall vs flush: stallE=1 for 2 cycles → ctrlE held. stallE=1 and flushE=1 together → ctrlE = 0 next edge.
4. Divide: div $1,$2 (0x0022001A), DIV_CYCLES=34 → md_startE pulses once; md_busyE/stall_req high 33 cycles; ctrlM = 0 throughout; div reaches M on the first unstalled edge after busy clears.
5. Exception mid-divide: flush_exc at busy cycle 10 → ctrlE/M/W = 0, md_busyE = 0 next edge, no restart.
6. Invalid opcode 0xFC000000 → ctrlD: is_invalid=1, valid=1, other fields 0; reaches ctrlW at +3 unchanged.
